tlb_op_ctrl: RTL and testbench

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

---
 rtl/mmu_pkg.sv | 25 ++
 rtl/tlb_op_ctrl_if.sv | 14 +
 rtl/tlb_random.sv | 26 ++
 rtl/tlb_op_ctrl.sv | 120 ++++++++++++
 tb/tb_tlb_op_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB op encoding, default TLB size, index type and controller states.
package mmu_pkg;

    localparam int TLB_NUM_DEFAULT = 16;

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_t;

    typedef logic [$clog2(TLB_NUM_DEFAULT)-1:0] tlb_index_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    function automatic logic is_write(input tlb_op_t op);
        return (op == TLBWI) || (op == TLBWR);
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// TLB instruction request/completion handshake between the pipeline (master) and tlb_op_ctrl (slave).
interface tlb_op_ctrl_if;
    import mmu_pkg::*;

    logic    op_valid;
    tlb_op_t op_type;
    logic    op_ready;
    logic    done;
    tlb_op_t done_type;

    modport master (output op_valid, op_type, input op_ready, done, done_type);
    modport slave  (input op_valid, op_type, output op_ready, done, done_type);

endinterface

// File: rtl/tlb_random.sv
// CP0 Random counter: free-running down-counter that wraps to TLB_NUM-1 at or below Wired.
module tlb_random #(
    parameter  int TLB_NUM = 16,
    localparam int IW      = $clog2(TLB_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] wired,
    input  logic          wired_we,
    output logic [IW-1:0] random
);

    localparam logic [IW-1:0] RAND_MAX = IW'(TLB_NUM - 1);

    // Wired >= TLB_NUM-1 keeps random <= wired every cycle, so it stays pinned at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random <= RAND_MAX;
        end else if (wired_we || (random <= wired)) begin
            random <= RAND_MAX;
        end else begin
            random <= random - IW'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller (TLBP/TLBR/TLBWI/TLBWR) with CP0 Random generation.
// Optional feature: define TLB_WRITE_FLUSH_EN to pulse flush_out when a TLB write completes.
module tlb_op_ctrl
    import mmu_pkg::*;
#(
    parameter  int TLB_NUM = TLB_NUM_DEFAULT,
    localparam int IW      = $clog2(TLB_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    tlb_op_ctrl_if.slave  op_bus,
    input  logic [IW-1:0] cp0_index,
    input  logic [IW-1:0] cp0_wired,
    input  logic          wired_we,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [IW-1:0] tlb_r_index,
    output logic          tlbp_req,
    input  logic          tlbp_found,
    input  logic [IW-1:0] tlbp_index,
    input  logic          r_valid_in,
    output logic          p_found,
    output logic [IW-1:0] p_index,
    output logic [IW-1:0] random,
    output logic          flush_out
);

    ctrl_state_t   state;
    tlb_op_t       op_type_q;
    logic [IW-1:0] op_index_q;
    logic [IW-1:0] op_random_q;
    logic          done_q;
    tlb_op_t       done_type_q;

    tlb_random #(.TLB_NUM(TLB_NUM)) u_random (
        .clk      (clk),
        .reset    (reset),
        .wired    (cp0_wired),
        .wired_we (wired_we),
        .random   (random)
    );

    assign op_bus.op_ready  = (state == IDLE);
    assign op_bus.done      = done_q;
    assign op_bus.done_type = done_type_q;
    assign tlb_r_index      = op_index_q;

    // Strobes are set on accept so they are valid for exactly the EXEC cycle(s).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_type_q   <= TLBP;
            op_index_q  <= '0;
            op_random_q <= '0;
            tlb_we      <= 1'b0;
            tlb_w_index <= '0;
            tlbp_req    <= 1'b0;
            p_found     <= 1'b0;
            p_index     <= '0;
            done_q      <= 1'b0;
            done_type_q <= TLBP;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (op_bus.op_valid) begin
                        state       <= EXEC;
                        op_type_q   <= op_bus.op_type;
                        op_index_q  <= cp0_index;
                        op_random_q <= random;
                        tlb_we      <= is_write(op_bus.op_type);
                        tlb_w_index <= (op_bus.op_type == TLBWR) ? random : cp0_index;
                        tlbp_req    <= (op_bus.op_type == TLBP);
                    end
                end
                EXEC: begin
                    tlb_we   <= 1'b0;
                    tlbp_req <= 1'b0;
                    if (op_type_q == TLBP) begin
                        p_found <= tlbp_found;
                        p_index <= tlbp_index;
                    end
                    if ((op_type_q != TLBR) || r_valid_in) begin
                        state       <= DONE;
                        done_q      <= 1'b1;
                        done_type_q <= op_type_q;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    tlb_we   <= 1'b0;
                    tlbp_req <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TLB_WRITE_FLUSH_EN
    logic flush_q;

    // Write ops never stall in EXEC, so this lines up with the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= (state == EXEC) && is_write(op_type_q);
        end
    end

    assign flush_out = flush_q;
`else
    assign flush_out = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed self-checking bench for tlb_op_ctrl (TLB_NUM=16); follows TLB_WRITE_FLUSH_EN if defined.
module tb_tlb_op_ctrl;
    import mmu_pkg::*;

`ifdef TLB_WRITE_FLUSH_EN
    localparam logic FLUSH_ON = 1'b1;
`else
    localparam logic FLUSH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cp0_index;
    logic [3:0] cp0_wired;
    logic       wired_we;
    logic       tlb_we;
    logic [3:0] tlb_w_index;
    logic [3:0] tlb_r_index;
    logic       tlbp_req;
    logic       tlbp_found;
    logic [3:0] tlbp_index;
    logic       r_valid_in;
    logic       p_found;
    logic [3:0] p_index;
    logic [3:0] random;
    logic       flush_out;

    int total_checks = 0;
    int bad_checks   = 0;

    tlb_op_ctrl_if bus ();

    tlb_op_ctrl #(.TLB_NUM(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_bus      (bus),
        .cp0_index   (cp0_index),
        .cp0_wired   (cp0_wired),
        .wired_we    (wired_we),
        .tlb_we      (tlb_we),
        .tlb_w_index (tlb_w_index),
        .tlb_r_index (tlb_r_index),
        .tlbp_req    (tlbp_req),
        .tlbp_found  (tlbp_found),
        .tlbp_index  (tlbp_index),
        .r_valid_in  (r_valid_in),
        .p_found     (p_found),
        .p_index     (p_index),
        .random      (random),
        .flush_out   (flush_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input tlb_op_t op, input logic [3:0] idx);
        bus.op_valid = valid;
        bus.op_type  = op;
        cp0_index    = idx;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        applyStimulus(1'b0, TLBP, 4'd0);
        cp0_wired  = 4'd0;
        wired_we   = 1'b0;
        tlbp_found = 1'b0;
        tlbp_index = 4'd0;
        r_valid_in = 1'b0;
        repeat (3) tick();

        checkOutput("rst_random",   random, 15);
        checkOutput("rst_ready",    bus.op_ready, 1);
        checkOutput("rst_p_found",  p_found, 0);
        checkOutput("rst_p_index",  p_index, 0);
        checkOutput("rst_tlb_we",   tlb_we, 0);
        checkOutput("rst_done",     bus.done, 0);
        checkOutput("rst_tlbp_req", tlbp_req, 0);
        checkOutput("rst_flush",    flush_out, 0);

        // random walks 15..0 then wraps with wired=0
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            checkOutput("rand_seq", random, (k == 16) ? 15 : 15 - k);
            if (k < 16) tick();
        end

        // wired=4 written while random=9
        repeat (6) tick();
        checkOutput("rand_before_wired", random, 9);
        cp0_wired = 4'd4;
        wired_we  = 1'b1;
        tick();
        wired_we = 1'b0;
        checkOutput("rand_wired_load", random, 15);
        for (int k = 1; k <= 11; k++) begin
            tick();
            checkOutput("rand_wired_seq", random, 15 - k);
        end
        tick();
        checkOutput("rand_wired_wrap", random, 15);

        cp0_wired = 4'd0;
        wired_we  = 1'b1;
        tick();
        wired_we = 1'b0;

        // TLBWI index 5
        applyStimulus(1'b1, TLBWI, 4'd5);
        checkOutput("wi_ready_pre", bus.op_ready, 1);
        tick();
        applyStimulus(1'b0, TLBP, 4'd0);
        checkOutput("wi_we",      tlb_we, 1);
        checkOutput("wi_w_index", tlb_w_index, 5);
        checkOutput("wi_busy",    bus.op_ready, 0);
        checkOutput("wi_no_done", bus.done, 0);
        tick();
        checkOutput("wi_done",      bus.done, 1);
        checkOutput("wi_done_type", bus.done_type, 2);
        checkOutput("wi_flush",     flush_out, FLUSH_ON);
        checkOutput("wi_we_off",    tlb_we, 0);
        tick();
        checkOutput("wi_done_off",  bus.done, 0);
        checkOutput("wi_flush_off", flush_out, 0);
        checkOutput("wi_ready",     bus.op_ready, 1);

        // TLBWR accepted at random=7, wired_we during EXEC must not disturb it
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        repeat (8) tick();
        checkOutput("wr_rand_pre", random, 7);
        applyStimulus(1'b1, TLBWR, 4'd2);
        tick();
        applyStimulus(1'b0, TLBP, 4'd0);
        wired_we = 1'b1;
        checkOutput("wr_we",      tlb_we, 1);
        checkOutput("wr_w_index", tlb_w_index, 7);
        checkOutput("wr_random",  random, 6);
        tick();
        wired_we = 1'b0;
        checkOutput("wr_done",      bus.done, 1);
        checkOutput("wr_done_type", bus.done_type, 3);
        checkOutput("wr_flush",     flush_out, FLUSH_ON);
        checkOutput("wr_we_off",    tlb_we, 0);
        checkOutput("wr_rand_load", random, 15);
        tick();

        // TLBP hit at 3; second request while busy is dropped
        tlbp_found = 1'b1;
        tlbp_index = 4'd3;
        applyStimulus(1'b1, TLBP, 4'd0);
        tick();
        checkOutput("p_req",  tlbp_req, 1);
        checkOutput("p_busy", bus.op_ready, 0);
        applyStimulus(1'b1, TLBWI, 4'd9);
        tick();
        checkOutput("p_done",      bus.done, 1);
        checkOutput("p_done_type", bus.done_type, 0);
        checkOutput("p_found",     p_found, 1);
        checkOutput("p_index",     p_index, 3);
        checkOutput("p_req_off",   tlbp_req, 0);
        checkOutput("p_no_we",     tlb_we, 0);
        checkOutput("p_no_flush",  flush_out, 0);
        applyStimulus(1'b0, TLBP, 4'd0);
        tlbp_found = 1'b0;
        tlbp_index = 4'd7;
        tick();
        checkOutput("p_ready",   bus.op_ready, 1);
        checkOutput("p_ignored", tlb_we, 0);
        checkOutput("p_idle",    bus.done, 0);

        // TLBR with one wait cycle
        applyStimulus(1'b1, TLBR, 4'd11);
        tick();
        applyStimulus(1'b0, TLBP, 4'd0);
        checkOutput("r_index",   tlb_r_index, 11);
        checkOutput("r_busy",    bus.op_ready, 0);
        checkOutput("r_no_req",  tlbp_req, 0);
        checkOutput("r_no_we",   tlb_we, 0);
        tick();
        checkOutput("r_wait_done", bus.done, 0);
        checkOutput("r_wait_busy", bus.op_ready, 0);
        r_valid_in = 1'b1;
        tick();
        r_valid_in = 1'b0;
        checkOutput("r_done",      bus.done, 1);
        checkOutput("r_done_type", bus.done_type, 1);
        checkOutput("r_no_flush",  flush_out, 0);
        checkOutput("r_p_found",   p_found, 1);
        checkOutput("r_p_index",   p_index, 3);
        tick();
        checkOutput("r_ready", bus.op_ready, 1);

        // reset during EXEC of a TLBWI
        applyStimulus(1'b1, TLBWI, 4'd4);
        tick();
        applyStimulus(1'b0, TLBP, 4'd0);
        checkOutput("ra_we_pre", tlb_we, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("ra_we",      tlb_we, 0);
        checkOutput("ra_ready",   bus.op_ready, 1);
        checkOutput("ra_p_found", p_found, 0);
        checkOutput("ra_random",  random, 15);
        tick();
        reset = 1'b0;
        checkOutput("ra_ready_rel", bus.op_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("ra_no_done", bus.done, 0);
            checkOutput("ra_no_we",   tlb_we, 0);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
